multi_dataflow_sobel_mdc_job_sequencer: RTL and testbench
=========================================================

MULTI_DATAFLOW_SOBEL_MDC_JOB_SEQUENCER -- requirements
Module: multi_dataflow_sobel_mdc_job_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the output-pixel counter and the expected-count register.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, the idle-output cycle limit for the watchdog.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock, rising edge; rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have clear_i  in  1  synchronous soft clear, equivalent to reset.
REQ-005 SHALL have job_valid_i / job_ready_o  in/out  1 / 1  job request handshake.
REQ-006 SHALL have job_width_i, job_height_i  in  16 each  image dimensions in pixels.
REQ-007 SHALL have size_valid_o / size_ready_i / size_data_o  out/in/out  1 / 1 / 32  size-token stream to the engine's in_size sink.
REQ-008 SHALL have eng_clear_o, eng_start_o  out  1 each  engine control pulses.
REQ-009 SHALL have eng_ready_i  in  1  engine ready flag.
REQ-010 SHALL have out_valid_i, out_ready_i  in  1 each  observed out_pel handshake.
REQ-011 SHALL have busy_o  out  1  job in progress.
REQ-012 SHALL have evt_done_o  out  1  one-cycle job completion event.
REQ-013 SHALL have out_cnt_o  out  CNT_W  output beats in the current job.
REQ-014 SHALL have err_timeout_o  out  1  sticky watchdog error.

Function
REQ-015 SHALL implement the states IDLE, CLEAR, SIZE_W, SIZE_H, START, RUN, DONE.
REQ-016 IDLE SHALL drive job_ready_o=1; on job_valid_i&job_ready_o it SHALL latch width and height, set expected=width*height (32-bit product, zero-extended or truncated to CNT_W), and go to CLEAR.
REQ-017 A job with width==0 or height==0 SHALL be accepted and SHALL go directly to DONE with no size tokens and no start pulse.
REQ-018 CLEAR SHALL assert eng_clear_o for exactly one cycle, zero out_cnt, and go to SIZE_W.
REQ-019 SIZE_W SHALL drive size_valid_o=1 with size_data_o={16'b0,width}, holding data stable until size_ready_i, then go to SIZE_H.
REQ-020 SIZE_H SHALL do the same with {16'b0,height} and then go to START.
REQ-021 size_valid_o SHALL NOT deassert before its handshake completes.
REQ-022 START SHALL wait for eng_ready_i=1, assert eng_start_o for exactly one cycle, and go to RUN.
REQ-023 RUN SHALL increment out_cnt on every cycle with out_valid_i&out_ready_i; on the handshake that makes out_cnt==expected it SHALL go to DONE.
REQ-024 Handshakes observed outside RUN SHALL be ignored.
REQ-025 out_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-026 DONE SHALL assert evt_done_o for exactly one cycle and return to IDLE; a new job SHALL be acceptable the following cycle.
REQ-027 busy_o SHALL equal (state != IDLE).
REQ-028 out_cnt_o SHALL hold its final value in IDLE until the next job leaves CLEAR.
REQ-029 Only one job SHALL be in flight at a time; job_ready_o SHALL be 0 in all states except IDLE.
REQ-030 clear_i SHALL take priority over every transition and SHALL return the block to IDLE on the next edge.

Reset
REQ-031 Reset SHALL asynchronously force the following values: state=IDLE, job_ready_o=1, size_valid_o=0, size_data_o=0, eng_clear_o=0, eng_start_o=0, busy_o=0, evt_done_o=0, out_cnt_o=0, err_timeout_o=0, expected=0.
REQ-032 Reset asserted mid-job SHALL abandon the job with no evt_done_o pulse.

Configuration
REQ-033 Macro SOBEL_MDC_JOB_SEQ_WATCHDOG_EN SHALL control the watchdog.
REQ-034 When SOBEL_MDC_JOB_SEQ_WATCHDOG_EN is defined, a counter SHALL run in RUN and reset on each output handshake; reaching TIMEOUT_CYC SHALL set err_timeout_o (sticky until reset or clear_i) and force DONE with the evt_done_o pulse.
REQ-035 When SOBEL_MDC_JOB_SEQ_WATCHDOG_EN is undefined, err_timeout_o SHALL be tied to 0 and RUN SHALL wait indefinitely.

Structure
REQ-036 The state enum and a job descriptor struct (width, height) SHALL live in multi_dataflow_sobel_mdc_package, alongside MULTI_DATAFLOW_SOBEL_MDC_CNT_LEN.
REQ-037 The beat counter with saturation SHALL be sub-module multi_dataflow_sobel_mdc_beat_counter, instantiated once for out_cnt and once for the watchdog.

Verification
REQ-038 Job 4x3 with size_ready_i always 1 and 12 output beats -> tokens 4 then 3, one eng_start_o, evt_done_o on the cycle after the 12th beat, out_cnt_o=12.
REQ-039 size_ready_i held low for 5 cycles in SIZE_W -> size_valid_o stays 1 and size_data_o stays 4 throughout; no start pulse before both tokens complete.
REQ-040 Job 0x5 -> no size_valid_o, no eng_start_o, evt_done_o within 3 cycles of acceptance.
REQ-041 rst_ni pulsed low after 6 of 12 beats -> all outputs at reset values, no evt_done_o; a new 2x2 job then completes with out_cnt_o=4.
REQ-042 With the watchdog enabled and TIMEOUT_CYC=16, a job 2x2 with only 1 beat -> err_timeout_o=1 and evt_done_o after 16 idle cycles; with the watchdog disabled the block stays in RUN.
REQ-043 out_valid_i=1 with out_ready_i=0 for 10 cycles, then 4 handshakes on a 2x2 job -> out_cnt_o counts only the 4 handshakes.

Source files
------------

// File: rtl/multi_dataflow_sobel_mdc_package.sv
// rtl/multi_dataflow_sobel_mdc_package.sv - shared types for the sobel MDC job sequencer
// Holds the sequencer state enum, the job descriptor and the default counter width.
package multi_dataflow_sobel_mdc_package;

   localparam int MULTI_DATAFLOW_SOBEL_MDC_CNT_LEN = 32;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SIZE_W,
      SIZE_H,
      START,
      RUN,
      DONE
   } seq_state_e;

   typedef struct packed {
      logic [15:0] width;
      logic [15:0] height;
   } job_desc_t;

   function automatic logic [31:0] job_pixels(job_desc_t job);
      return {16'b0, job.width} * {16'b0, job.height};
   endfunction

endpackage

// File: rtl/multi_dataflow_sobel_mdc_job_sequencer_if.sv
// rtl/multi_dataflow_sobel_mdc_job_sequencer_if.sv - job request and size-token handshakes
// master is the host/engine side, slave is the sequencer.
interface multi_dataflow_sobel_mdc_job_sequencer_if;
   logic        job_valid_i;
   logic        job_ready_o;
   logic [15:0] job_width_i;
   logic [15:0] job_height_i;
   logic        size_valid_o;
   logic        size_ready_i;
   logic [31:0] size_data_o;

   modport master (
      output job_valid_i, job_width_i, job_height_i, size_ready_i,
      input  job_ready_o, size_valid_o, size_data_o
   );

   modport slave (
      input  job_valid_i, job_width_i, job_height_i, size_ready_i,
      output job_ready_o, size_valid_o, size_data_o
   );
endinterface

// File: rtl/multi_dataflow_sobel_mdc_beat_counter.sv
// rtl/multi_dataflow_sobel_mdc_beat_counter.sv - saturating up-counter with synchronous clear
// Clear wins over increment; the count sticks at all-ones instead of wrapping.
module multi_dataflow_sobel_mdc_beat_counter #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + W'(1);
      end
   end

endmodule

// File: rtl/multi_dataflow_sobel_mdc_job_sequencer.sv
// rtl/multi_dataflow_sobel_mdc_job_sequencer.sv - one-job-at-a-time sequencer for the sobel MDC engine
// Optional idle-output watchdog enabled by SOBEL_MDC_JOB_SEQ_WATCHDOG_EN.
module multi_dataflow_sobel_mdc_job_sequencer
   import multi_dataflow_sobel_mdc_package::*;
#(
   parameter int CNT_W       = MULTI_DATAFLOW_SOBEL_MDC_CNT_LEN,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        clear_i,
   multi_dataflow_sobel_mdc_job_sequencer_if.slave     job_if,
   output logic                                        eng_clear_o,
   output logic                                        eng_start_o,
   input  logic                                        eng_ready_i,
   input  logic                                        out_valid_i,
   input  logic                                        out_ready_i,
   output logic                                        busy_o,
   output logic                                        evt_done_o,
   output logic [CNT_W-1:0]                            out_cnt_o,
   output logic                                        err_timeout_o
);

   seq_state_e       state_q, state_d;
   job_desc_t        job_q, job_d, job_new;
   logic [CNT_W-1:0] expected_q, expected_d;
   logic [CNT_W-1:0] cnt_next;
   logic             beat;
   logic             wd_hit;

   assign job_new  = '{width: job_if.job_width_i, height: job_if.job_height_i};
   assign beat     = (state_q == RUN) && out_valid_i && out_ready_i;
   // Value the counter will hold after this beat, honouring saturation.
   assign cnt_next = (out_cnt_o == '1) ? out_cnt_o : out_cnt_o + CNT_W'(1);

   multi_dataflow_sobel_mdc_beat_counter #(.W(CNT_W)) u_out_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clear_i || (state_q == CLEAR)),
      .inc_i  (beat),
      .cnt_o  (out_cnt_o)
   );

`ifdef SOBEL_MDC_JOB_SEQ_WATCHDOG_EN
   logic [CNT_W-1:0] wd_cnt;
   logic             err_q;

   multi_dataflow_sobel_mdc_beat_counter #(.W(CNT_W)) u_wd_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clear_i || (state_q != RUN) || beat),
      .inc_i  (state_q == RUN),
      .cnt_o  (wd_cnt)
   );

   assign wd_hit = (state_q == RUN) && (wd_cnt == CNT_W'(TIMEOUT_CYC));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (clear_i) begin
         err_q <= 1'b0;
      end else if (wd_hit) begin
         err_q <= 1'b1;
      end
   end

   assign err_timeout_o = err_q;
`else
   assign wd_hit        = 1'b0;
   assign err_timeout_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         job_q      <= '0;
         expected_q <= '0;
      end else begin
         state_q    <= state_d;
         job_q      <= job_d;
         expected_q <= expected_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      job_d      = job_q;
      expected_d = expected_q;
      case (state_q)
         IDLE: begin
            if (job_if.job_valid_i) begin
               job_d      = job_new;
               expected_d = CNT_W'(job_pixels(job_new));
               // Empty images never touch the engine.
               state_d    = ((job_new.width == '0) || (job_new.height == '0)) ? DONE : CLEAR;
            end
         end
         CLEAR:   state_d = SIZE_W;
         SIZE_W:  if (job_if.size_ready_i) state_d = SIZE_H;
         SIZE_H:  if (job_if.size_ready_i) state_d = START;
         START:   if (eng_ready_i) state_d = RUN;
         RUN: begin
            if ((beat && (cnt_next == expected_q)) || wd_hit) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d    = IDLE;
         job_d      = '0;
         expected_d = '0;
      end
   end

   assign job_if.job_ready_o  = (state_q == IDLE);
   assign job_if.size_valid_o = (state_q == SIZE_W) || (state_q == SIZE_H);
   assign job_if.size_data_o  = (state_q == SIZE_W) ? {16'b0, job_q.width}  :
                                (state_q == SIZE_H) ? {16'b0, job_q.height} : 32'b0;
   assign eng_clear_o         = (state_q == CLEAR);
   assign eng_start_o         = (state_q == START) && eng_ready_i;
   assign busy_o              = (state_q != IDLE);
   assign evt_done_o          = (state_q == DONE);

endmodule

// File: tb/tb_multi_dataflow_sobel_mdc_job_sequencer.sv
// tb/tb_multi_dataflow_sobel_mdc_job_sequencer.sv - directed bench for the sobel MDC job sequencer
// Table of jobs plus hand-written sequences for stalls, empty jobs, reset, clear and watchdog.
module tb_multi_dataflow_sobel_mdc_job_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clear_i = 1'b0;
   logic        eng_clear_o, eng_start_o, eng_ready_i, out_valid_i, out_ready_i;
   logic        busy_o, evt_done_o, err_timeout_o;
   logic [31:0] out_cnt_o;

   multi_dataflow_sobel_mdc_job_sequencer_if jif ();

   multi_dataflow_sobel_mdc_job_sequencer #(.CNT_W(32), .TIMEOUT_CYC(16)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clear_i       (clear_i),
      .job_if        (jif.slave),
      .eng_clear_o   (eng_clear_o),
      .eng_start_o   (eng_start_o),
      .eng_ready_i   (eng_ready_i),
      .out_valid_i   (out_valid_i),
      .out_ready_i   (out_ready_i),
      .busy_o        (busy_o),
      .evt_done_o    (evt_done_o),
      .out_cnt_o     (out_cnt_o),
      .err_timeout_o (err_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int w;
      int h;
      int beats;
      int exp_cnt;
   } vec_t;

   vec_t        vecs[5];
   int          n_chk = 0, n_err = 0;
   int          n_start = 0, n_done = 0, n_clr = 0, n_sv = 0, hold_bad = 0;
   int          tok[$];
   logic        prev_v = 1'b0, prev_r = 1'b0;
   logic [31:0] prev_d = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Observe just before each rising edge, once inputs have settled.
   always begin
      @(negedge clk_i);
      #4;
      if (rst_ni) begin
         if (eng_start_o) n_start++;
         if (evt_done_o)  n_done++;
         if (eng_clear_o) n_clr++;
         if (jif.size_valid_o) n_sv++;
         if (jif.size_valid_o && jif.size_ready_i) tok.push_back(int'(jif.size_data_o));
         if (prev_v && !prev_r && (!jif.size_valid_o || jif.size_data_o != prev_d)) hold_bad++;
         prev_v = jif.size_valid_o;
         prev_r = jif.size_ready_i;
         prev_d = jif.size_data_o;
      end else begin
         prev_v = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic submit(input int w, input int h);
      int k = 0;
      while (!jif.job_ready_o && k < 50) begin
         tick(1);
         k++;
      end
      chk("job_ready_wait", jif.job_ready_o, 1);
      jif.job_width_i  = 16'(w);
      jif.job_height_i = 16'(h);
      jif.job_valid_i  = 1'b1;
      tick(1);
      jif.job_valid_i  = 1'b0;
   endtask

   task automatic wait_start(input int s0);
      int k = 0;
      while (n_start == s0 && k < 50) begin
         tick(1);
         k++;
      end
      chk("start_seen", n_start, s0 + 1);
   endtask

   task automatic drive_beats(input int n);
      out_valid_i = 1'b1;
      out_ready_i = 1'b1;
      tick(n);
      out_valid_i = 1'b0;
      out_ready_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int k = 0;
      while (n_done == d0 && k < budget) begin
         tick(1);
         k++;
      end
      chk("done_seen", n_done, d0 + 1);
   endtask

   initial begin
      int s0, d0, c0, v0;
      int bad;

      vecs[0] = '{w: 4, h: 3, beats: 12, exp_cnt: 12};
      vecs[1] = '{w: 2, h: 2, beats: 4,  exp_cnt: 4};
      vecs[2] = '{w: 1, h: 1, beats: 1,  exp_cnt: 1};
      vecs[3] = '{w: 3, h: 1, beats: 3,  exp_cnt: 3};
      vecs[4] = '{w: 1, h: 5, beats: 5,  exp_cnt: 5};

      jif.job_valid_i  = 1'b0;
      jif.job_width_i  = '0;
      jif.job_height_i = '0;
      jif.size_ready_i = 1'b1;
      eng_ready_i      = 1'b1;
      out_valid_i      = 1'b0;
      out_ready_i      = 1'b0;
      tick(3);
      rst_ni = 1'b1;
      tick(1);

      chk("rst_job_ready", jif.job_ready_o, 1);
      chk("rst_size_valid", jif.size_valid_o, 0);
      chk("rst_size_data", jif.size_data_o, 0);
      chk("rst_eng_clear", eng_clear_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", evt_done_o, 0);
      chk("rst_out_cnt", out_cnt_o, 0);
      chk("rst_err", err_timeout_o, 0);

      // Handshakes in IDLE must not count.
      drive_beats(3);
      chk("idle_beats_ignored", out_cnt_o, 0);

      for (int i = 0; i < 5; i++) begin
         s0 = n_start; d0 = n_done; c0 = n_clr;
         tok.delete();
         submit(vecs[i].w, vecs[i].h);
         wait_start(s0);
         chk("tok_count", tok.size(), 2);
         if (tok.size() == 2) begin
            chk("tok_width", tok[0], vecs[i].w);
            chk("tok_height", tok[1], vecs[i].h);
         end
         chk("eng_clear_once", n_clr, c0 + 1);
         drive_beats(vecs[i].beats);
         tick(1);
         chk("done_after_last_beat", n_done, d0 + 1);
         chk("out_cnt_final", out_cnt_o, vecs[i].exp_cnt);
         chk("idle_after_done", busy_o, 0);
         chk("start_once", n_start, s0 + 1);
      end

      // Size token stalled for five cycles in SIZE_W.
      jif.size_ready_i = 1'b0;
      s0 = n_start; d0 = n_done;
      tok.delete();
      submit(4, 3);
      tick(1);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (!jif.size_valid_o || jif.size_data_o != 32'd4 || n_start != s0) bad++;
         tick(1);
      end
      chk("stall_hold", bad, 0);
      jif.size_ready_i = 1'b1;
      wait_start(s0);
      chk("stall_tok_count", tok.size(), 2);
      if (tok.size() == 2) begin
         chk("stall_tok_w", tok[0], 4);
         chk("stall_tok_h", tok[1], 3);
      end
      drive_beats(12);
      tick(1);
      chk("stall_done", n_done, d0 + 1);
      chk("stall_cnt", out_cnt_o, 12);

      // Empty job goes straight to DONE.
      s0 = n_start; d0 = n_done; v0 = n_sv;
      submit(0, 5);
      tick(2);
      chk("zero_done", n_done, d0 + 1);
      chk("zero_no_tokens", n_sv, v0);
      chk("zero_no_start", n_start, s0);
      chk("zero_idle", busy_o, 0);

      // Reset mid-job after 6 of 12 beats.
      s0 = n_start;
      submit(4, 3);
      wait_start(s0);
      drive_beats(6);
      d0 = n_done;
      rst_ni = 1'b0;
      #2;
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_job_ready", jif.job_ready_o, 1);
      chk("mid_rst_cnt", out_cnt_o, 0);
      chk("mid_rst_start", eng_start_o, 0);
      chk("mid_rst_done_out", evt_done_o, 0);
      tick(2);
      rst_ni = 1'b1;
      tick(2);
      chk("mid_rst_no_done", n_done, d0);
      s0 = n_start;
      submit(2, 2);
      wait_start(s0);
      drive_beats(4);
      tick(1);
      chk("post_rst_done", n_done, d0 + 1);
      chk("post_rst_cnt", out_cnt_o, 4);

      // Valid without ready must not count.
      s0 = n_start; d0 = n_done;
      submit(2, 2);
      wait_start(s0);
      out_valid_i = 1'b1;
      out_ready_i = 1'b0;
      tick(10);
      chk("noready_cnt", out_cnt_o, 0);
      chk("noready_busy", busy_o, 1);
      drive_beats(4);
      tick(1);
      chk("noready_final_cnt", out_cnt_o, 4);
      chk("noready_done", n_done, d0 + 1);

      // Watchdog: 2x2 job with a single beat.
      s0 = n_start; d0 = n_done;
      submit(2, 2);
      wait_start(s0);
      drive_beats(1);
`ifdef SOBEL_MDC_JOB_SEQ_WATCHDOG_EN
      wait_done(d0, 40);
      tick(1);
      chk("wd_err", err_timeout_o, 1);
      chk("wd_idle", busy_o, 0);
      chk("wd_cnt", out_cnt_o, 1);
      clear_i = 1'b1;
      tick(1);
      clear_i = 1'b0;
      chk("wd_err_cleared", err_timeout_o, 0);
`else
      tick(40);
      chk("nowd_busy", busy_o, 1);
      chk("nowd_no_done", n_done, d0);
      chk("nowd_err", err_timeout_o, 0);
      d0 = n_done;
      clear_i = 1'b1;
      tick(1);
      clear_i = 1'b0;
      tick(1);
      chk("clear_idle", busy_o, 0);
      chk("clear_cnt", out_cnt_o, 0);
      chk("clear_no_done", n_done, d0);
`endif

      chk("size_hold_property", hold_bad, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
